// File: rtl/apc_pkg.sv
// Shared types and defaults for the approximate parallel counter accumulator.
// Mode enum, default sizing and a parameter-to-mode helper.
package apc_pkg;

  typedef enum logic {
    APC_EXACT  = 1'b0,
    APC_APPROX = 1'b1
  } apc_mode_e;

  localparam int APC_INUM_DEF   = 16;
  localparam int APC_WINLOG_DEF = 8;

  function automatic apc_mode_e apc_mode(input int approx);
    return (approx != 0) ? APC_APPROX : APC_EXACT;
  endfunction

endpackage

// File: rtl/apc_popcount.sv
// Combinational count of set bits across INUM stochastic streams.
// Exact popcount, or an OR-paired approximation that saves adder width.
module apc_popcount
  import apc_pkg::*;
#(
  parameter int INUM   = APC_INUM_DEF,
  parameter int APPROX = 1
) (
  input  logic [INUM-1:0]        in,
  output logic [$clog2(INUM):0]  cnt
);

  localparam int CW    = $clog2(INUM) + 1;
  localparam int NPAIR = INUM / 2;
  localparam apc_mode_e MODE = apc_mode(APPROX);

  generate
    if (MODE == APC_APPROX) begin : g_approx
      logic [NPAIR-1:0] pair_or;
      logic [CW-1:0]    pair_sum;

      for (genvar gi = 0; gi < NPAIR; gi++) begin : g_pair
        assign pair_or[gi] = in[2*gi] | in[2*gi+1];
      end

      // Every pair but the last weighs 2; the last pair weighs 1, capping at INUM-1.
      always_comb begin
        pair_sum = '0;
        for (int i = 0; i < NPAIR - 1; i++) begin
          pair_sum = pair_sum + CW'(pair_or[i]);
        end
        cnt = (pair_sum << 1) + CW'(pair_or[NPAIR-1]);
      end
    end else begin : g_exact
      always_comb begin
        cnt = '0;
        for (int i = 0; i < INUM; i++) begin
          cnt = cnt + CW'(in[i]);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/apc_acc_add.sv
// Stochastic scaled adder: registers a per-sample count, compares it to a
// random number for the output bit, and sums counts over fixed windows.
module apc_acc_add
  import apc_pkg::*;
#(
  parameter int INUM    = APC_INUM_DEF,
  parameter int LOGINUM = $clog2(INUM),
  parameter int WINLOG  = APC_WINLOG_DEF,
  parameter int APPROX  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clr,
  input  logic [INUM-1:0]             in,
  input  logic [LOGINUM-1:0]          randNum,
  output logic                        out,
  output logic [LOGINUM:0]            cnt_o,
  output logic [LOGINUM+WINLOG:0]     acc_o,
  output logic                        acc_valid
);

  localparam int AW = LOGINUM + WINLOG + 1;

  logic [LOGINUM:0]  pop_cnt;

  logic [LOGINUM:0]  cnt_reg,       cnt_next;
  logic              cnt_vld_reg,   cnt_vld_next;
  logic [WINLOG-1:0] wcnt_reg,      wcnt_next;
  logic [AW-1:0]     acc_reg,       acc_next;
  logic [AW-1:0]     acc_o_reg,     acc_o_next;
  logic              acc_valid_reg, acc_valid_next;
  logic [AW-1:0]     acc_sum;
  logic              win_last;

  apc_popcount #(
    .INUM   (INUM),
    .APPROX (APPROX)
  ) u_popcount (
    .in  (in),
    .cnt (pop_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      cnt_vld_reg   <= 1'b0;
      wcnt_reg      <= '0;
      acc_reg       <= '0;
      acc_o_reg     <= '0;
      acc_valid_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      cnt_vld_reg   <= cnt_vld_next;
      wcnt_reg      <= wcnt_next;
      acc_reg       <= acc_next;
      acc_o_reg     <= acc_o_next;
      acc_valid_reg <= acc_valid_next;
    end
  end

  assign acc_sum  = acc_reg + AW'(cnt_reg);
  assign win_last = (wcnt_reg == {WINLOG{1'b1}});

  always_comb begin
    cnt_next       = cnt_reg;
    cnt_vld_next   = 1'b0;
    wcnt_next      = wcnt_reg;
    acc_next       = acc_reg;
    acc_o_next     = acc_o_reg;
    acc_valid_next = 1'b0;

    if (en) begin
      cnt_next     = pop_cnt;
      cnt_vld_next = 1'b1;
    end

    // Restart wins over window completion; a sample loaded alongside it is dropped.
    if (clr) begin
      cnt_vld_next = 1'b0;
      wcnt_next    = '0;
      acc_next     = '0;
    end else if (cnt_vld_reg) begin
      if (win_last) begin
        acc_o_next     = acc_sum;
        acc_next       = '0;
        wcnt_next      = '0;
        acc_valid_next = 1'b1;
      end else begin
        acc_next  = acc_sum;
        wcnt_next = wcnt_reg + 1'b1;
      end
    end
  end

  assign out       = (cnt_reg > {1'b0, randNum});
  assign cnt_o     = cnt_reg;
  assign acc_o     = acc_o_reg;
  assign acc_valid = acc_valid_reg;

endmodule

// File: tb/tb_apc_acc_add.sv
// Directed bench for apc_acc_add: approximate and exact instances share stimulus;
// window pulses are predicted into per-instance queues and matched on arrival.
`timescale 1ns/1ps
module tb_apc_acc_add;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic [15:0] in_v;
  logic [3:0]  rnd;

  logic        out_a, out_e;
  logic [4:0]  cnt_a, cnt_e;
  logic [6:0]  acc_a, acc_e;
  logic        av_a, av_e;

  apc_acc_add #(.INUM(16), .WINLOG(2), .APPROX(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in(in_v), .randNum(rnd),
    .out(out_a), .cnt_o(cnt_a), .acc_o(acc_a), .acc_valid(av_a)
  );

  apc_acc_add #(.INUM(16), .WINLOG(2), .APPROX(0)) dut_e (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in(in_v), .randNum(rnd),
    .out(out_e), .cnt_o(cnt_e), .acc_o(acc_e), .acc_valid(av_e)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int cyc;
  int checks;
  int errors;
  int pulses[2];
  int m_cnt[2];
  int m_vld[2];
  int m_win[2];
  int m_sum[2];
  int m_acco[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference count; index 0 is the approximate instance.
  function automatic int ref_cnt(input logic [15:0] v, input bit approx);
    int n;
    n = 0;
    if (!approx) begin
      for (int i = 0; i < 16; i++) n += int'(v[i]);
    end else begin
      for (int p = 0; p < 7; p++) if (v[2*p] || v[2*p+1]) n += 2;
      if (v[14] || v[15]) n += 1;
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_vld[d] = 0; m_win[d] = 0; m_sum[d] = 0; m_acco[d] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_edge(input bit e, input bit c, input logic [15:0] v);
    exp_t x;
    for (int d = 0; d < 2; d++) begin
      if (c) begin
        m_win[d] = 0;
        m_sum[d] = 0;
      end else if (m_vld[d] != 0) begin
        m_sum[d] += m_cnt[d];
        m_win[d]++;
        if (m_win[d] == 4) begin
          x.cyc = cyc + 1;
          x.val = m_sum[d];
          if (d == 0) q0.push_back(x); else q1.push_back(x);
          m_acco[d] = m_sum[d];
          m_win[d]  = 0;
          m_sum[d]  = 0;
        end
      end
      if (e) m_cnt[d] = ref_cnt(v, d == 0);
      m_vld[d] = (e && !c) ? 1 : 0;
    end
  endtask

  task automatic check_outputs();
    logic       av;
    logic [6:0] ao;
    logic [4:0] co;
    logic       o;
    bit         exp_pulse;
    exp_t       x;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        av = av_a; ao = acc_a; co = cnt_a; o = out_a;
        exp_pulse = (q0.size() > 0) && (q0[0].cyc == cyc);
      end else begin
        av = av_e; ao = acc_e; co = cnt_e; o = out_e;
        exp_pulse = (q1.size() > 0) && (q1[0].cyc == cyc);
      end
      chk($sformatf("acc_valid[%0d] cyc%0d", d, cyc), 32'(av), 32'(exp_pulse));
      if (exp_pulse) begin
        if (d == 0) x = q0.pop_front(); else x = q1.pop_front();
        chk($sformatf("acc_o_pulse[%0d] cyc%0d", d, cyc), 32'(ao), 32'(x.val));
      end
      if (av === 1'b1) pulses[d]++;
      chk($sformatf("cnt_o[%0d] cyc%0d", d, cyc), 32'(co), 32'(m_cnt[d]));
      chk($sformatf("acc_o_hold[%0d] cyc%0d", d, cyc), 32'(ao), 32'(m_acco[d]));
      chk($sformatf("out[%0d] cyc%0d", d, cyc), 32'(o), 32'(m_cnt[d] > int'(rnd)));
    end
  endtask

  task automatic step(input bit e, input bit c, input logic [15:0] v);
    en   = e;
    clr  = c;
    in_v = v;
    model_edge(e, c, v);
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " cnt_a"}, 32'(cnt_a), 32'd0);
    chk({tag, " cnt_e"}, 32'(cnt_e), 32'd0);
    chk({tag, " acc_a"}, 32'(acc_a), 32'd0);
    chk({tag, " acc_e"}, 32'(acc_e), 32'd0);
    chk({tag, " av_a"},  32'(av_a),  32'd0);
    chk({tag, " av_e"},  32'(av_e),  32'd0);
    chk({tag, " out_a"}, 32'(out_a), 32'd0);
    chk({tag, " out_e"}, 32'(out_e), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; in_v = '0; rnd = '0;
    cyc = 0; checks = 0; errors = 0;
    pulses[0] = 0; pulses[1] = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #10;
    check_all_zero("reset");
    #10 rst_n = 1'b1;

    // All ones: approximate saturates at 15, exact reaches 16
    step(1'b1, 1'b0, 16'hFFFF);
    chk("cnt_a_ffff", 32'(cnt_a), 32'd15);
    chk("cnt_e_ffff", 32'(cnt_e), 32'd16);
    for (int r = 0; r < 16; r++) begin
      rnd = 4'(r);
      #1;
      chk($sformatf("out_a_ffff r%0d", r), 32'(out_a), 32'(r < 15));
      chk($sformatf("out_e_ffff r%0d", r), 32'(out_e), 32'd1);
    end
    rnd = 4'd7;

    // Alternating bits: every pair set in approximate mode
    step(1'b1, 1'b0, 16'h5555);
    chk("cnt_a_5555", 32'(cnt_a), 32'd15);
    chk("cnt_e_5555", 32'(cnt_e), 32'd8);
    chk("out_e_5555 r7", 32'(out_e), 32'd1);
    rnd = 4'd8;
    #1;
    chk("out_e_5555 r8", 32'(out_e), 32'd0);
    rnd = 4'd3;

    // Continuous valid samples: pulse every 4 edges
    step(1'b0, 1'b1, 16'h0000);
    pulses[0] = 0; pulses[1] = 0;
    repeat (12) step(1'b1, 1'b0, 16'h000F);
    step(1'b0, 1'b0, 16'h0000);
    chk("pulses_cont_a", 32'(pulses[0]), 32'd3);
    chk("pulses_cont_e", 32'(pulses[1]), 32'd3);
    chk("acc_e_cont", 32'(acc_e), 32'd16);
    chk("acc_a_cont", 32'(acc_a), 32'd16);

    // Alternating enable: pulse every 8 edges
    step(1'b0, 1'b1, 16'h0000);
    pulses[0] = 0; pulses[1] = 0;
    for (int i = 0; i < 16; i++) step((i % 2) == 0, 1'b0, 16'h000F);
    step(1'b0, 1'b0, 16'h0000);
    chk("pulses_alt_a", 32'(pulses[0]), 32'd2);
    chk("pulses_alt_e", 32'(pulses[1]), 32'd2);

    // Clear coincident with window completion
    step(1'b0, 1'b1, 16'h0000);
    pulses[0] = 0; pulses[1] = 0;
    repeat (4) step(1'b1, 1'b0, 16'h00FF);
    step(1'b1, 1'b1, 16'h00FF);
    chk("clr_no_pulse_e", 32'(av_e), 32'd0);
    chk("clr_acc_hold_e", 32'(acc_e), 32'd16);
    repeat (4) step(1'b1, 1'b0, 16'h00FF);
    chk("clr_early_pulses_e", 32'(pulses[1]), 32'd0);
    step(1'b1, 1'b0, 16'h00FF);
    chk("clr_late_pulse_e", 32'(av_e), 32'd1);
    chk("clr_late_acc_e", 32'(acc_e), 32'd32);
    chk("clr_late_acc_a", 32'(acc_a), 32'd32);
    step(1'b0, 1'b0, 16'h0000);

    // Asynchronous reset mid-window
    rnd = 4'd0;
    repeat (2) step(1'b1, 1'b0, 16'hFFFF);
    #10 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    pulses[0] = 0; pulses[1] = 0;
    #10 rst_n = 1'b1;
    repeat (4) step(1'b1, 1'b0, 16'hFFFF);
    chk("post_reset_no_early_pulse", 32'(pulses[1]), 32'd0);
    step(1'b0, 1'b0, 16'h0000);
    chk("post_reset_pulses_e", 32'(pulses[1]), 32'd1);
    chk("post_reset_acc_e", 32'(acc_e), 32'd64);
    chk("post_reset_acc_a", 32'(acc_a), 32'd60);
    step(1'b0, 1'b0, 16'h0000);

    chk("pending_q0", 32'(q0.size()), 32'd0);
    chk("pending_q1", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
